// File: rtl/lsu_stage.sv
// Load/store unit stage: turns an EX-stage memory op into one dmem request and writes back the load result.
// Latency: pass-through results 1 cycle; stores 2 cycles; loads 3 cycles with immediate ready and response.
// Backpressure: stall is held while a memory op is in flight; REQ holds all dmem_* outputs until dmem_req_ready.
//
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   ex_valid, mem_read, mem_write, funct3, alu_result, store_data, rd, flush - EX-stage op and pipeline kill
//   stall                - freezes the upstream pipeline
//   dmem_req_*/dmem_addr/dmem_we/dmem_be/dmem_wdata, dmem_rsp_valid/dmem_rdata - data memory port
//   wb_valid, wb_rd, wb_data - single-cycle writeback pulse
//   misalign             - one-cycle trap pulse (only active when MISALIGN_TRAP_EN is defined)
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned H/HU/W accesses instead of
// issuing them on the aligned-down lanes.
module lsu_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        stall,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Access size code: 0 byte, 1 half, 2 word. Unlisted funct3 encodings fall to word.
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 2'd0;
      3'b001, 3'b101: return 2'd1;
      default:        return 2'd2;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        store_q;
  logic        kill_q, kill_d;

  logic        wb_valid_d;
  logic [4:0]  wb_rd_d;
  logic [31:0] wb_data_d;

  logic        mem_op;
  logic        accept;
  logic        trap_in;
  logic        take;
  logic        in_req;

  logic [1:0]  sz_q;
  logic        zext_q;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign mem_op = mem_read | mem_write;
  assign accept = (state_q == IDLE) & ex_valid & mem_op & ~flush;
  assign stall  = (state_q != IDLE) | accept;

`ifdef MISALIGN_TRAP_EN
  logic [1:0] sz_in;
  logic       misalign_q;

  assign sz_in   = size_of(funct3);
  assign trap_in = ((sz_in == 2'd1) & alu_result[0]) |
                   ((sz_in == 2'd2) & (|alu_result[1:0]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= accept & trap_in;
  end

  assign misalign = misalign_q;
`else
  assign trap_in  = 1'b0;
  assign misalign = 1'b0;
`endif

  // A trapped access is accepted (stall asserts for that cycle) but never latched.
  assign take = accept & ~trap_in;

  // Operand capture for the in-flight op; both mem_read and mem_write high is a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      sdata_q <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      store_q <= 1'b0;
    end else if (take) begin
      addr_q  <= alu_result;
      sdata_q <= store_data;
      f3_q    <= funct3;
      rd_q    <= rd;
      store_q <= mem_write & ~mem_read;
    end
  end

  // Byte-lane steering from the latched address; misaligned halves use the lane chosen by addr[1].
  assign sz_q   = size_of(f3_q);
  assign zext_q = (f3_q == 3'b100) | (f3_q == 3'b101);

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = sdata_q;
    case (sz_q)
      2'd0: begin
        lane_be    = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{sdata_q[7:0]}};
      end
      2'd1: begin
        lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{sdata_q[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = sdata_q;
      end
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    load_data = dmem_rdata;
    case (sz_q)
      2'd0:    load_data = zext_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    load_data = zext_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Request outputs are only non-zero in REQ, so they read as 0 during and after reset.
  assign in_req         = (state_q == REQ);
  assign dmem_req_valid = in_req;
  assign dmem_addr      = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dmem_we        = in_req & store_q;
  assign dmem_be        = in_req ? lane_be : 4'd0;
  assign dmem_wdata     = (in_req & store_q) ? lane_wdata : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      kill_q   <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      wb_valid <= wb_valid_d;
      wb_rd    <= wb_rd_d;
      wb_data  <= wb_data_d;
    end
  end

  // kill_q remembers a flush that arrived after the request was issued: the response
  // must still be consumed, but its writeback is dropped.
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd;
    wb_data_d  = wb_data;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = REQ;
          kill_d  = 1'b0;
        end else if (ex_valid && !mem_op && !flush) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd;
          wb_data_d  = alu_result;
        end
      end
      REQ: begin
        // Once ready is seen the memory has the request; flush then only suppresses writeback.
        if (dmem_req_ready) begin
          state_d = store_q ? IDLE : WAIT;
          kill_d  = flush;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (flush) kill_d = 1'b1;
        if (dmem_rsp_valid) begin
          state_d = IDLE;
          if (!(kill_q || flush)) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = load_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Randomized bench for lsu_stage with a byte-arithmetic reference model and a small word memory.
// Each operation is driven to completion; outputs are sampled away from the rising edge.
// Build with MISALIGN_TRAP_EN defined to exercise the trapping variant.
module tb_lsu_stage;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        flush;
  logic        stall;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem [16];
  logic [31:0] last_wb_data;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_be;

  lsu_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .funct3         (funct3),
    .alu_result     (alu_result),
    .store_data     (store_data),
    .rd             (rd),
    .flush          (flush),
    .stall          (stall),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_addr      (dmem_addr),
    .dmem_we        (dmem_we),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .misalign       (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sz_bytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int lane_off(input int sz, input logic [31:0] a);
    int lo;
    lo = int'(a % 32'd4);
    if (sz == 4) return 0;
    return (lo / sz) * sz;
  endfunction

  function automatic logic [3:0] be_of(input int sz, input int off);
    logic [31:0] m;
    m = ((32'd1 << sz) - 32'd1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] wd_of(input int sz, input logic [31:0] sd);
    if (sz == 1) return {24'd0, sd[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'd0, sd[15:0]} * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] load_of(input logic [31:0] word, input logic [2:0] f3, input logic [31:0] a);
    int          sz, off;
    logic [31:0] mask, v;
    sz   = sz_bytes(f3);
    off  = lane_off(sz, a);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (word >> (8 * off)) & mask;
    if (sz < 4 && !(f3 == 3'd4 || f3 == 3'd5) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit trap_of(input int sz, input logic [31:0] a);
    return TRAP_EN && ((sz == 2 && (a % 32'd2) != 0) || (sz == 4 && (a % 32'd4) != 0));
  endfunction

  // kind: 0 pass-through, 1 load, 2 store, 3 read+write (acts as load)
  // fl_mode: 0 none, 1 flush with the op in IDLE, 2 flush in first REQ cycle, 3 flush in first WAIT cycle
  // Starts and ends at a falling edge with the DUT in IDLE.
  task automatic do_op(input int kind, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] r,
                       input int rdy_dly, input int rsp_dly, input int fl_mode);
    int          sz, off, idx;
    bit          is_mem, is_ld, is_st, trap, hs, got_rsp, abort;
    logic [3:0]  e_be;
    logic [31:0] e_wd, word;
    is_mem = (kind != 0);
    is_ld  = (kind == 1) || (kind == 3);
    is_st  = (kind == 2);
    sz     = sz_bytes(f3);
    off    = lane_off(sz, a);
    e_be   = be_of(sz, off);
    e_wd   = is_st ? wd_of(sz, sd) : 32'd0;
    trap   = trap_of(sz, a);
    idx    = int'(a[5:2]);

    ex_valid   = 1'b1;
    mem_read   = is_ld;
    mem_write  = (kind == 2) || (kind == 3);
    funct3     = f3;
    alu_result = a;
    store_data = sd;
    rd         = r;
    flush      = (fl_mode == 1);
    #1;
    check("idle_req_valid", dmem_req_valid, 0);
    check("accept_stall", stall, is_mem && fl_mode != 1);

    @(negedge clk);
    ex_valid   = 1'b0;
    flush      = 1'b0;
    mem_read   = 1'($urandom);
    mem_write  = 1'($urandom);
    funct3     = 3'($urandom);
    alu_result = $urandom;
    store_data = $urandom;
    rd         = 5'($urandom);
    #1;
    if (!is_mem || fl_mode == 1) begin
      check("pt_wb_valid", wb_valid, !is_mem && fl_mode != 1);
      if (!is_mem && fl_mode != 1) begin
        check("pt_wb_rd", wb_rd, r);
        check("pt_wb_data", wb_data, a);
        last_wb_data = wb_data;
      end
      check("pt_req_valid", dmem_req_valid, 0);
      return;
    end
    check("mem_wb_valid", wb_valid, 0);
    check("misalign", misalign, trap);
    if (trap) begin
      check("trap_req_valid", dmem_req_valid, 0);
      check("trap_stall", stall, 0);
      @(negedge clk);
      check("trap_pulse_end", misalign, 0);
      check("trap_wb_valid", wb_valid, 0);
      return;
    end

    hs    = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 64 && !hs && !abort; i++) begin
      flush          = (fl_mode == 2 && i == 0);
      dmem_req_ready = (i >= rdy_dly) && !(fl_mode == 2 && i == 0);
      #1;
      check("req_valid", dmem_req_valid, 1);
      check("req_addr", dmem_addr, {a[31:2], 2'b00});
      check("req_be", dmem_be, e_be);
      check("req_we", dmem_we, is_st);
      check("req_wdata", dmem_wdata, e_wd);
      check("req_stall", stall, 1);
      hs = dmem_req_ready;
      if (hs) begin
        last_addr  = dmem_addr;
        last_be    = dmem_be;
        last_wdata = dmem_wdata;
      end
      @(negedge clk);
      flush          = 1'b0;
      dmem_req_ready = 1'b0;
      #1;
      if (fl_mode == 2 && i == 0) begin
        check("abort_req_valid", dmem_req_valid, 0);
        check("abort_wb_valid", wb_valid, 0);
        check("abort_stall", stall, 0);
        abort = 1'b1;
      end else if (!hs) begin
        check("req_wb_valid", wb_valid, 0);
      end
    end
    if (abort) return;

    if (is_st) begin
      check("st_wb_valid", wb_valid, 0);
      check("st_stall", stall, 0);
      check("st_req_valid", dmem_req_valid, 0);
      for (int b = 0; b < 4; b++)
        if (e_be[b]) mem[idx][b*8 +: 8] = e_wd[b*8 +: 8];
      return;
    end

    word    = mem[idx];
    got_rsp = 1'b0;
    for (int j = 0; j < 64 && !got_rsp; j++) begin
      flush          = (fl_mode == 3 && j == 0);
      dmem_rsp_valid = (j >= rsp_dly);
      dmem_rdata     = dmem_rsp_valid ? word : $urandom;
      #1;
      check("wait_stall", stall, 1);
      check("wait_req_valid", dmem_req_valid, 0);
      got_rsp = dmem_rsp_valid;
      @(negedge clk);
      flush          = 1'b0;
      dmem_rsp_valid = 1'b0;
      dmem_rdata     = $urandom;
      check("ld_wb_valid", wb_valid, got_rsp && fl_mode != 3);
      if (got_rsp && fl_mode != 3) begin
        check("ld_wb_rd", wb_rd, r);
        check("ld_wb_data", wb_data, load_of(word, f3, a));
        last_wb_data = wb_data;
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    ex_valid       = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    funct3         = 3'd0;
    alu_result     = 32'd0;
    store_data     = 32'd0;
    rd             = 5'd0;
    flush          = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = 32'd0;
    last_wb_data   = 32'd0;
    last_addr      = 32'hFFFF_FFFF;
    last_wdata     = 32'd0;
    last_be        = 4'd0;
    for (int k = 0; k < 16; k++) mem[k] = $urandom;

    #1;
    check("rst_req_valid", dmem_req_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_misalign", misalign, 0);
    check("rst_stall", stall, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // LB sign-extended from the top byte, immediate ready and next-cycle response
    mem[0] = 32'h80FF_FF12;
    do_op(1, 3'b000, 32'h0000_1003, 32'd0, 5'd3, 0, 0, 0);
    check("lb_example_data", last_wb_data, 32'hFFFF_FF80);

    // SH to the upper half
    do_op(2, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 5'd4, 0, 0, 0);
    check("sh_example_be", {28'd0, last_be}, 32'h0000_000C);
    check("sh_example_wdata", last_wdata, 32'hBEEF_BEEF);

    // LW with ready held low for 4 cycles, then a pass-through right behind it
    do_op(1, 3'b010, 32'h0000_1008, 32'd0, 5'd5, 4, 1, 0);
    do_op(0, 3'b000, 32'h1234_5678, 32'd0, 5'd6, 0, 0, 0);

    // LHU flushed in WAIT, then the next op is accepted
    do_op(1, 3'b101, 32'h0000_1006, 32'd0, 5'd7, 0, 2, 3);
    do_op(1, 3'b101, 32'h0000_1006, 32'd0, 5'd8, 0, 0, 0);

    // read+write high behaves as a load; flush in IDLE and in REQ
    do_op(3, 3'b010, 32'h0000_100C, 32'hDEAD_BEEF, 5'd9, 1, 0, 0);
    do_op(2, 3'b010, 32'h0000_1010, 32'hCAFE_F00D, 5'd10, 0, 0, 1);
    do_op(2, 3'b000, 32'h0000_1011, 32'hCAFE_F00D, 5'd11, 2, 0, 2);
    do_op(0, 3'b000, 32'h0BAD_F00D, 32'd0, 5'd12, 0, 0, 1);

    // misaligned LW
    last_addr = 32'hFFFF_FFFF;
    do_op(1, 3'b010, 32'h0000_1001, 32'd0, 5'd13, 0, 0, 0);
    if (!TRAP_EN) check("lw_misaligned_addr", last_addr, 32'h0000_1000);

    // reset while a request is pending, then a stray response in IDLE
    do_op(0, 3'b000, 32'h5A5A_A5A5, 32'd0, 5'd14, 0, 0, 0);
    ex_valid   = 1'b1;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    funct3     = 3'b010;
    alu_result = 32'h0000_1014;
    rd         = 5'd15;
    @(negedge clk);
    ex_valid       = 1'b0;
    dmem_req_ready = 1'b0;
    #1;
    check("rst_mid_pre_valid", dmem_req_valid, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_req_valid", dmem_req_valid, 0);
    check("rst_mid_addr", dmem_addr, 0);
    check("rst_mid_be", {28'd0, dmem_be}, 0);
    check("rst_mid_we", dmem_we, 0);
    check("rst_mid_wdata", dmem_wdata, 0);
    check("rst_mid_wb_valid", wb_valid, 0);
    check("rst_mid_wb_rd", {27'd0, wb_rd}, 0);
    check("rst_mid_wb_data", wb_data, 0);
    check("rst_mid_misalign", misalign, 0);
    check("rst_mid_stall", stall, 0);
    @(negedge clk);
    reset          = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = $urandom;
    #1;
    check("stray_rsp_stall", stall, 0);
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    check("stray_rsp_wb_valid", wb_valid, 0);
    check("stray_rsp_req_valid", dmem_req_valid, 0);

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      int kind, fsel, fm;
      kind = $urandom_range(0, 3);
      fsel = $urandom_range(0, 9);
      fm   = 0;
      if (fsel == 0) fm = 1;
      else if (fsel == 1) fm = 2;
      else if (fsel == 2 && (kind == 1 || kind == 3)) fm = 3;
      do_op(kind, 3'($urandom_range(0, 7)), 32'h0000_1000 + 32'($urandom_range(0, 63)),
            $urandom, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), fm);
    end

    @(negedge clk);
    check("final_wb_valid", wb_valid, 0);
    check("final_stall", stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
- REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
- REQ-002 SHALL have port: reset  in  1  asynchronous, active-high; clears all state immediately.
- REQ-003 SHALL have port: ex_valid  in  1  EX stage presents an instruction this cycle.
- REQ-004 SHALL have port: mem_read, mem_write  in  1 each  load / store select; both low means pass-through.
- REQ-005 SHALL have port: funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- REQ-006 SHALL have port: alu_result  in  32  effective address, or pass-through result.
- REQ-007 SHALL have port: store_data  in  32  rs2 value.
- REQ-008 SHALL have port: rd  in  5  destination register.
- REQ-009 SHALL have port: flush  in  1  kill the in-flight op.
- REQ-010 SHALL have port: stall  out  1  freezes the upstream pipeline.
- REQ-011 SHALL have ports: dmem_req_valid out 1; dmem_req_ready in 1; dmem_addr out 32, word-aligned; dmem_we out 1; dmem_be out 4; dmem_wdata out 32; dmem_rsp_valid in 1; dmem_rdata in 32.
- REQ-012 SHALL have ports: wb_valid out 1; wb_rd out 5; wb_data out 32.
- REQ-013 SHALL have port: misalign  out  1  one-cycle pulse on a trapped access.

Function
- REQ-014 SHALL implement FSM states IDLE, REQ, WAIT.
- REQ-015 IDLE with ex_valid and a memory op SHALL latch address, data, funct3 and rd, then go to REQ.
- REQ-016 IDLE with ex_valid, no memory op and no flush SHALL register wb_valid=1, wb_rd=rd, wb_data=alu_result for exactly one cycle (1-cycle latency).
- REQ-017 In REQ, dmem_req_valid SHALL be 1 and all dmem_* outputs SHALL stay stable until dmem_req_ready=1.
- REQ-018 On the REQ handshake, a load SHALL go to WAIT and a store SHALL go to IDLE with wb_valid=0.
- REQ-019 WAIT SHALL hold until dmem_rsp_valid=1, then return to IDLE and pulse wb_valid with the extracted load data.
- REQ-020 Store byte enables: SB be=1<<addr[1:0], wdata=byte replicated x4; SH be=0011 or 1100 by addr[1], wdata=half replicated x2; SW be=1111.
- REQ-021 Load extraction: select byte addr[1:0] or half addr[1]; sign-extend B/H, zero-extend BU/HU; W passes unchanged.
- REQ-022 dmem_addr SHALL equal {addr[31:2],2'b00}; dmem_we SHALL be 1 only for stores.
- REQ-023 stall SHALL equal (state!=IDLE) OR (state==IDLE AND ex_valid AND (mem_read OR mem_write) AND NOT flush).
- REQ-024 mem_read and mem_write both high SHALL be handled as a load; the write is ignored.
- REQ-025 flush in IDLE SHALL discard the incoming op.
- REQ-026 flush in REQ before the handshake SHALL abort to IDLE without issuing a request.
- REQ-027 flush in WAIT SHALL complete the response but suppress wb_valid.
- REQ-028 funct3 values not listed in REQ-005 SHALL be treated as W.
- REQ-029 Back-to-back operations SHALL be accepted in the cycle the FSM returns to IDLE.

Reset
- REQ-030 reset SHALL force state to IDLE and drive every output to 0 (stall follows REQ-023) without waiting for clk.
- REQ-031 reset mid-transaction SHALL abandon it; a late dmem_rsp_valid arriving in IDLE SHALL be ignored.

Configuration
- REQ-032 With MISALIGN_TRAP_EN defined: a H/HU access with addr[0]=1, or a W access with addr[1:0]!=0, SHALL issue no request, pulse misalign for one cycle, keep wb_valid=0 and stay in IDLE.
- REQ-033 Without MISALIGN_TRAP_EN: misalign SHALL be tied 0, and misaligned accesses SHALL proceed using the aligned-down lanes of REQ-020 and REQ-021.

Verification
- REQ-034 LB with addr=0x1003, rdata=0x80FF_FF12, ready immediate, rsp the next cycle -> wb_data=0xFFFF_FF80, wb_valid 3 cycles after accept.
- REQ-035 SH with addr=0x2002, store_data=0x0000_BEEF -> be=1100, wdata=0xBEEF_BEEF, we=1, wb_valid=0.
- REQ-036 LW with dmem_req_ready low for 4 cycles -> dmem_addr and be held stable and stall=1 throughout; single wb_valid after rsp.
- REQ-037 flush in WAIT during LHU -> response consumed, wb_valid stays 0, next op accepted.
- REQ-038 reset asserted in REQ -> outputs 0 immediately, state IDLE; stray rsp_valid ignored.
- REQ-039 LW to 0x1001 with MISALIGN_TRAP_EN -> misalign=1 for one cycle and no dmem_req_valid; without the macro -> dmem_addr=0x1000.
